spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_shift_engine.sv | 171 +++++++++++++++++
 tb/tb_spi_shift_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one word of 1..32 bits per start, any CPOL/CPHA,
// programmable sclk half-period, multi-slave select.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ss_n released, sclk follows live cpol, waiting for start
// SETUP | slaves selected, first bit on mosi, one half-period of lead-in
// SHIFT | 2*len sclk edges, one every half-period
// HOLD  | sclk parked at cpol, slaves still selected for one half-period
module spi_shift_engine #(
    parameter int NUMBER_SLAVES = 1,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [31:0]              tx_data,
    input  logic [5:0]               xfer_len,
    input  logic [NUMBER_SLAVES-1:0] ss_mask,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [DIV_WIDTH-1:0]     clk_div,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              rx_data,
    output logic                     sclk,
    output logic                     mosi,
    input  logic                     miso,
    output logic [NUMBER_SLAVES-1:0] ss_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [6:0]           EDGE_ONE = 7'd1;

    state_t               state;
    logic [31:0]          tx_sh;
    logic [31:0]          rx_sh;
    logic [5:0]           len_q;
    logic                 cpha_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [6:0]           edge_cnt;

    logic [5:0]           len_eff;
    logic [5:0]           align_sh;
    logic [31:0]          tx_aligned;
    logic                 div_tc;
    logic                 leading;
    logic                 first_edge;
    logic                 last_edge;
    logic                 sample_edge;
    logic                 shift_edge;

    // tx word is left-justified at start so mosi always comes from bit 31
    always_comb begin
        len_eff    = xfer_len;
        if ((xfer_len == 6'd0) || (xfer_len > 6'd32)) begin
            len_eff = 6'd32;
        end
        align_sh   = 6'd32 - len_eff;
        tx_aligned = tx_data << align_sh;
    end

    // edge_cnt counts down from 2*len, so an even count is a leading edge
    always_comb begin
        div_tc      = (div_cnt == '0);
        leading     = ~edge_cnt[0];
        first_edge  = (edge_cnt == {len_q, 1'b0});
        last_edge   = (edge_cnt == EDGE_ONE);
        sample_edge = cpha_q ? ~leading : leading;
        shift_edge  = cpha_q ? (leading && !first_edge) : (!leading && !last_edge);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            tx_sh    <= '0;
            rx_sh    <= '0;
            len_q    <= '0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    mosi <= 1'b0;
                    ss_n <= '1;
                    busy <= 1'b0;
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        ss_n    <= ~ss_mask;
                        len_q   <= len_eff;
                        cpha_q  <= cpha;
                        div_q   <= clk_div;
                        div_cnt <= clk_div;
                        tx_sh   <= tx_aligned;
                        mosi    <= tx_aligned[31];
                        rx_sh   <= '0;
                    end
                end

                SETUP: begin
                    if (div_tc) begin
                        state    <= SHIFT;
                        div_cnt  <= div_q;
                        edge_cnt <= {len_q, 1'b0};
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                SHIFT: begin
                    if (div_tc) begin
                        sclk     <= ~sclk;
                        div_cnt  <= div_q;
                        edge_cnt <= edge_cnt - EDGE_ONE;
                        if (sample_edge) begin
                            rx_sh <= {rx_sh[30:0], miso};
                        end
                        if (shift_edge) begin
                            tx_sh <= {tx_sh[30:0], 1'b0};
                            mosi  <= tx_sh[30];
                        end
                        if (last_edge) begin
                            state <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                HOLD: begin
                    if (div_tc) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sh;
                        ss_n    <= '1;
                        mosi    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ss_n  <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Randomized loopback/tied-miso bench for spi_shift_engine with a queue
// scoreboard; expected words come from length/mask arithmetic only.
module tb_spi_shift_engine;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [31:0]   tx_data;
    logic [5:0]    xfer_len;
    logic [NS-1:0] ss_mask;
    logic          cpol;
    logic          cpha;
    logic [15:0]   clk_div;
    logic          busy;
    logic          done;
    logic [31:0]   rx_data;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic [NS-1:0] ss_n;

    int miso_mode = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]   rx;
        logic [31:0]   bits;
        int            edges;
        int            busy_cyc;
        logic          cpol;
        logic          cpha;
        logic [NS-1:0] ss;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    spi_shift_engine #(.NUMBER_SLAVES(NS), .DIV_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .tx_data (tx_data),
        .xfer_len(xfer_len),
        .ss_mask (ss_mask),
        .cpol    (cpol),
        .cpha    (cpha),
        .clk_div (clk_div),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    // mode 0 = miso looped to mosi, 1 = tied high, 2 = tied low
    task automatic issue(input logic [31:0] tx, input logic [5:0] len, input logic [NS-1:0] mask,
                         input logic pol, input logic pha, input logic [15:0] div, input int mode);
        exp_t        e;
        int          n;
        logic [31:0] m;
        n = ((len == 6'd0) || (len > 6'd32)) ? 32 : int'(len);
        m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        e.bits     = tx & m;
        e.rx       = (mode == 0) ? (tx & m) : ((mode == 1) ? m : 32'd0);
        e.edges    = 2 * n;
        e.busy_cyc = (2 * n + 2) * (int'(div) + 1);
        e.cpol     = pol;
        e.cpha     = pha;
        e.ss       = ~mask;
        exp_q.push_back(e);
        miso_mode = mode;
        tx_data   = tx;
        xfer_len  = len;
        ss_mask   = mask;
        cpol      = pol;
        cpha      = pha;
        clk_div   = div;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        tx_data  = $urandom;
        xfer_len = 6'($urandom_range(0, 63));
        ss_mask  = 4'($urandom_range(0, 15));
        cpol     = 1'($urandom_range(0, 1));
        cpha     = 1'($urandom_range(0, 1));
        clk_div  = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    // monitor: accumulate edges/bits/busy per transfer, score on done
    int          mon_busy;
    int          mon_edges;
    logic [31:0] mon_bits;
    logic        mon_ss_bad;
    logic        prev_busy;
    logic        prev_sclk;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_busy   = 0;
            mon_edges  = 0;
            mon_bits   = '0;
            mon_ss_bad = 1'b0;
            prev_busy  = 1'b0;
            prev_sclk  = sclk;
        end else begin
            if (busy) begin
                mon_busy++;
                if (exp_q.size() == 0 || ss_n !== exp_q[0].ss) mon_ss_bad = 1'b1;
                if (prev_busy && sclk !== prev_sclk) begin
                    mon_edges++;
                    if (exp_q.size() > 0 && ((exp_q[0].cpha == 1'b0) == (mon_edges % 2 == 1)))
                        mon_bits = {mon_bits[30:0], mosi};
                end
            end else if (ss_n !== '1) begin
                mon_ss_bad = 1'b1;
            end
            if (done) begin
                check("busy_low_at_done", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", rx_data, mon_e.rx);
                    check("mosi_bits", mon_bits, mon_e.bits);
                    check("sclk_edges", mon_edges, mon_e.edges);
                    check("busy_cycles", mon_busy, mon_e.busy_cyc);
                    check("sclk_idle", {31'd0, sclk}, {31'd0, mon_e.cpol});
                    check("ss_n_ok", {31'd0, mon_ss_bad}, 32'd0);
                end
                mon_busy   = 0;
                mon_edges  = 0;
                mon_bits   = '0;
                mon_ss_bad = 1'b0;
            end
            prev_busy = busy;
            prev_sclk = sclk;
        end
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        tx_data  = '0;
        xfer_len = '0;
        ss_mask  = '0;
        cpol     = 1'b1;
        cpha     = 1'b1;
        clk_div  = '0;
        repeat (2) @(negedge clk);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ss_n", {28'd0, ss_n}, 32'h0000_000F);
        check("rst_rx", rx_data, 32'd0);

        // mode 3, first edge after release takes the start
        reset_n = 1'b1;
        issue(32'hDEAD_BEEF, 6'd32, 4'b0001, 1'b1, 1'b1, 16'd3, 0);
        check("first_start_busy", {31'd0, busy}, 32'd1);
        check("first_sclk_cpol", {31'd0, sclk}, 32'd1);
        wait_done();

        @(negedge clk);
        issue(32'h0000_00A5, 6'd8, 4'b0010, 1'b0, 1'b0, 16'd0, 0);
        wait_done();

        @(negedge clk);
        issue(32'h1234_5678, 6'd0, 4'b1000, 1'b0, 1'b1, 16'd1, 1);
        wait_done();

        // a second start mid-transfer must be dropped
        @(negedge clk);
        issue(32'h0000_003C, 6'd8, 4'b0001, 1'b0, 1'b0, 16'd1, 0);
        repeat (10) @(negedge clk);
        tx_data = 32'h0000_00C3;
        xfer_len = 6'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // back-to-back with start in the done cycle
        @(negedge clk);
        issue(32'h0000_0F0F, 6'd12, 4'b0100, 1'b1, 1'b0, 16'd0, 0);
        wait_done();
        issue(32'h0000_5A5A, 6'd16, 4'b0100, 1'b1, 1'b0, 16'd0, 0);
        check("one_idle_gap_busy", {31'd0, busy}, 32'd1);
        check("b2b_ss_n", {28'd0, ss_n}, 32'h0000_000B);
        wait_done();

        // abort mid-shift
        @(negedge clk);
        issue(32'h0000_0081, 6'd8, 4'b0011, 1'b0, 1'b0, 16'd1, 0);
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_ss_n", {28'd0, ss_n}, 32'h0000_000F);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sclk", {31'd0, sclk}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'h0000_0081, 6'd8, 4'b0011, 1'b0, 1'b0, 16'd1, 0);
        wait_done();

        for (int i = 0; i < 24; i++) begin
            logic [31:0]   r_tx;
            logic [5:0]    r_len;
            logic [NS-1:0] r_mask;
            logic          r_pol;
            logic          r_pha;
            logic [15:0]   r_div;
            int            r_mode;
            r_tx   = $urandom;
            r_len  = 6'($urandom_range(0, 40));
            r_mask = 4'($urandom_range(1, 15));
            r_pol  = 1'($urandom_range(0, 1));
            r_pha  = 1'($urandom_range(0, 1));
            r_div  = 16'($urandom_range(0, 3));
            r_mode = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(r_tx, r_len, r_mask, r_pol, r_pha, r_div, r_mode);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
